// File: rtl/instr_queue.sv
// Instruction queue between Fetch and Issue: circular buffer that stamps each
// accepted instruction with a 64-bit program order and supports redirect flush.
package rv32i_types;
  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
  } iq_entry_t;
endpackage

module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [63:0]      flush_order,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             deq_valid,
  input  logic             deq_ready,
  output iq_entry_t        deq_entry,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [IDX_W:0] ptr_t;

  ptr_t             r_head;
  ptr_t             r_tail;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_order;
  iq_entry_t        r_mem [DEPTH];

  logic      w_empty;
  logic      w_full;
  logic      w_enq;
  logic      w_deq;
  iq_entry_t w_head_entry;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                   (r_head[IDX_W] != r_tail[IDX_W]);

  // Ready does not look at deq_ready, so a full slot is never reused in the same cycle.
  assign enq_ready = !w_full && !flush && !rst;
  assign deq_valid = !w_empty && !flush;

  assign w_enq = enq_valid && enq_ready;
  assign w_deq = deq_valid && deq_ready;

  // NOTE: combinational blocks assign every output first, so no path can infer a latch.
  always_comb begin
    w_head_entry       = r_mem[r_head[IDX_W-1:0]];
    w_head_entry.valid = deq_valid;
  end

  assign deq_entry = w_head_entry;
  assign count     = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_order <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_order <= flush_order;
    end else begin
      if (w_enq) begin
        r_tail  <= r_tail + ptr_t'(1);
        r_order <= r_order + 64'd1;
      end
      if (w_deq) begin
        r_head <= r_head + ptr_t'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: slots are cleared on reset so deq_entry reads as all-zero afterwards; flush leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enq) begin
      r_mem[r_tail[IDX_W-1:0]] <= '{inst: enq_inst, pc: enq_pc, order: r_order, valid: 1'b1};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a random phase,
// all compared against a queue-based reference model.
module tb_instr_queue;
  import rv32i_types::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [63:0]      flush_order;
  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_inst;
  logic [31:0]      enq_pc;
  logic             deq_valid;
  logic             deq_ready;
  iq_entry_t        deq_entry;
  logic [CNT_W-1:0] count;

  instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_order (flush_order),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_inst    (enq_inst),
    .enq_pc      (enq_pc),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_entry   (deq_entry),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents in order and the next order stamp.
  iq_entry_t   mq[$];
  logic [63:0] m_order;

  int n_checks = 0;
  int n_pass   = 0;

  logic        ef;
  logic        df;
  logic [31:0] dpc;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle, entered and left at a negedge. Checks outputs against the
  // model, then advances the model by the rules for this cycle's inputs.
  task automatic cycle(input logic ev, input logic [31:0] inst, input logic [31:0] pc,
                       input logic dr, input logic fl, input logic [63:0] fo, input logic rs,
                       output logic enq_fire, output logic deq_fire, output logic [31:0] deq_pc);
    logic exp_er;
    logic exp_dv;
    enq_valid = ev; enq_inst = inst; enq_pc = pc;
    deq_ready = dr; flush = fl; flush_order = fo; rst = rs;
    #1;
    exp_er = (mq.size() < DEPTH) && !fl && !rs;
    exp_dv = (mq.size() != 0) && !fl;
    check("enq_ready", enq_ready, exp_er);
    check("deq_valid", deq_valid, exp_dv);
    check("count", count, mq.size());
    if (exp_dv) check("deq_entry", deq_entry, mq[0]);
    enq_fire = ev && exp_er;
    deq_fire = dr && exp_dv;
    deq_pc   = deq_entry.pc;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_order = '0;
    end else if (fl) begin
      mq.delete();
      m_order = fo;
    end else begin
      if (deq_fire) void'(mq.pop_front());
      if (enq_fire) begin
        mq.push_back('{inst: inst, pc: pc, order: m_order, valid: 1'b1});
        m_order++;
      end
    end
    @(negedge clk);
  endtask

  task automatic enq(input logic [31:0] pc);
    cycle(1'b1, $urandom, pc, 1'b0, 1'b0, 64'd0, 1'b0, ef, df, dpc);
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++)
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0, ef, df, dpc);
  endtask

  task automatic settle();
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; rst = 1'b0;
    flush_order = '0; enq_inst = '0; enq_pc = '0;
    #1;
  endtask

  initial begin
    int sent;
    int got;
    rst = 1'b1; flush = 1'b0; flush_order = '0; enq_valid = 1'b0;
    enq_inst = '0; enq_pc = '0; deq_ready = 1'b0;
    m_order = '0;
    @(negedge clk);

    // Reset
    repeat (2) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1, ef, df, dpc);
    settle();
    check("rst_deq_entry", deq_entry, '0);
    check("rst_count", count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);

    // Fill to full, then offer a 9th that must be held
    for (int i = 0; i < DEPTH; i++) enq($urandom);
    enq(32'hdead_0000);
    settle();
    check("full_count", count, DEPTH);
    check("full_enq_ready", enq_ready, 0);
    check("full_head_order", deq_entry.order, 0);

    // Full queue with enq and deq together: only the dequeue happens
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 64'd0, 1'b0, ef, df, dpc);
    settle();
    check("full_both_count", count, DEPTH - 1);
    check("full_both_enq_ready", enq_ready, 1);
    drain();

    // Stream 20 instructions with deq_ready toggling every cycle
    sent = 0;
    got  = 0;
    for (int c = 0; c < 200 && (sent < 20 || mq.size() != 0); c++) begin
      cycle(sent < 20, $urandom, 32'h1000 + 32'(4 * sent), (c % 2) == 1, 1'b0, 64'd0, 1'b0,
            ef, df, dpc);
      if (df) begin
        check("stream_pc", dpc, 32'h1000 + 32'(4 * got));
        got++;
      end
      if (ef) sent++;
    end
    check("stream_total", got, 20);

    // Enqueue into an empty queue with deq_ready high: visible only next cycle
    cycle(1'b1, $urandom, 32'h2000, 1'b1, 1'b0, 64'd0, 1'b0, ef, df, dpc);
    settle();
    check("empty_enq_dv", deq_valid, 1);
    check("empty_enq_pc", deq_entry.pc, 32'h2000);
    drain();

    // Flush with 5 queued and a same-cycle enqueue offer
    for (int i = 0; i < 5; i++) enq($urandom);
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, 64'd100, 1'b0, ef, df, dpc);
    settle();
    check("flush_count", count, 0);
    check("flush_deq_valid", deq_valid, 0);
    enq(32'h3000);
    settle();
    check("flush_next_order", deq_entry.order, 100);
    check("flush_next_pc", deq_entry.pc, 32'h3000);

    // Reset together with flush while 3 entries are queued
    enq($urandom);
    enq($urandom);
    cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, 64'd55, 1'b1, ef, df, dpc);
    settle();
    check("rst_flush_count", count, 0);
    check("rst_flush_entry", deq_entry, '0);
    enq(32'h4000);
    settle();
    check("rst_flush_order", deq_entry.order, 0);

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, {$urandom, $urandom}, $urandom_range(0, 63) == 0,
            ef, df, dpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
